// File: rtl/ex_mem_pkg.sv
// Shared widths, writeback constants and types for the EX/MEM pipeline register.
// The pipeline mode is decoded here so that every consumer applies the same priority.
package ex_mem_pkg;

  localparam int unsigned RegBus       = 32;
  localparam int unsigned RegAddrBus   = 5;
  localparam int unsigned DoubleRegBus = 64;

  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    MODE_RESET,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_ADVANCE
  } mode_e;

  typedef struct packed {
    logic [RegBus-1:0]     wdata;
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
  } wb_bundle_t;

  typedef struct packed {
    logic [DoubleRegBus-1:0] hilo;
    logic [1:0]              cnt;
  } carry_t;

  localparam wb_bundle_t NopBundle = '{
    wdata: ZeroWord,
    wd:    NOPRegAddr,
    wreg:  WriteDisable,
    hi:    ZeroWord,
    lo:    ZeroWord,
    whilo: WriteDisable
  };

  // stall_ex is stall[3], stall_mem is stall[4]; stall_mem without stall_ex advances.
  function automatic mode_e decode_mode(input logic rst, input logic stall_ex,
                                        input logic stall_mem);
    if (rst)             return MODE_RESET;
    else if (!stall_ex)  return MODE_ADVANCE;
    else if (!stall_mem) return MODE_BUBBLE;
    else                 return MODE_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX -> MEM writeback bundle plus the multiply-accumulate carry path back to EX.
interface ex_mem_if;
  import ex_mem_pkg::*;

  logic [5:0]              stall;
  logic [RegBus-1:0]       ex_wdata;
  logic [RegAddrBus-1:0]   ex_wd;
  logic                    ex_wreg;
  logic [RegBus-1:0]       ex_hi;
  logic [RegBus-1:0]       ex_lo;
  logic                    ex_whilo;
  logic [DoubleRegBus-1:0] hilo_i;
  logic [1:0]              cnt_i;

  logic [RegBus-1:0]       mem_wdata;
  logic [RegAddrBus-1:0]   mem_wd;
  logic                    mem_wreg;
  logic [RegBus-1:0]       mem_hi;
  logic [RegBus-1:0]       mem_lo;
  logic                    mem_whilo;
  logic [DoubleRegBus-1:0] hilo_o;
  logic [1:0]              cnt_o;

  modport master (
    output stall, ex_wdata, ex_wd, ex_wreg, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
    input  mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
  );

  modport slave (
    input  stall, ex_wdata, ex_wd, ex_wreg, ex_hi, ex_lo, ex_whilo, hilo_i, cnt_i,
    output mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: writeback bundle to MEM and madd/msub carry state back to EX.
// Reset is folded into the decoded mode, so both registers reset synchronously.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_mem_if.slave bus
);

  mode_e      mode;
  wb_bundle_t ex_bundle;
  wb_bundle_t bundle_d, bundle_q;
  carry_t     carry_d, carry_q;

  assign mode = decode_mode(rst, bus.stall[3], bus.stall[4]);

  always_comb begin
    ex_bundle = '{
      wdata: bus.ex_wdata,
      wd:    bus.ex_wd,
      wreg:  bus.ex_wreg,
      hi:    bus.ex_hi,
      lo:    bus.ex_lo,
      whilo: bus.ex_whilo
    };
  end

  always_comb begin
    bundle_d = bundle_q;
    unique case (mode)
      MODE_RESET,
      MODE_BUBBLE:  bundle_d = NopBundle;
      MODE_ADVANCE: bundle_d = ex_bundle;
      default:      bundle_d = bundle_q;
    endcase
  end

  // The carry is only live while EX is stalled; an advance retires the multi-cycle op.
  always_comb begin
    carry_d = carry_q;
    unique case (mode)
      MODE_RESET,
      MODE_ADVANCE: carry_d = '0;
      MODE_BUBBLE:  carry_d = '{hilo: bus.hilo_i, cnt: bus.cnt_i};
      default:      carry_d = carry_q;
    endcase
  end

  always_ff @(posedge clk) begin
    bundle_q <= bundle_d;
  end

  always_ff @(posedge clk) begin
    carry_q <= carry_d;
  end

  assign bus.mem_wdata = bundle_q.wdata;
  assign bus.mem_wd    = bundle_q.wd;
  assign bus.mem_wreg  = bundle_q.wreg;
  assign bus.mem_hi    = bundle_q.hi;
  assign bus.mem_lo    = bundle_q.lo;
  assign bus.mem_whilo = bundle_q.whilo;
  assign bus.hilo_o    = carry_q.hilo;
  assign bus.cnt_o     = carry_q.cnt;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed vector table for reset/advance/bubble/hold/madd cases,
// then random legal stall patterns checked against a rule-level reference model.
module tb_ex_mem;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  ex_mem_if bus ();

  ex_mem u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The pipeline controller never stalls MEM while EX runs.
  always @(posedge clk) begin
    assert (rst || !(bus.stall[4] && !bus.stall[3]))
      else $error("illegal stall vector %b", bus.stall);
  end

  typedef struct {
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    out_t        exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".mem_wd"},    64'(bus.mem_wd),    64'(e.wd));
    check({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(e.wdata));
    check({tag, ".mem_wreg"},  64'(bus.mem_wreg),  64'(e.wreg));
    check({tag, ".mem_hi"},    64'(bus.mem_hi),    64'(e.hi));
    check({tag, ".mem_lo"},    64'(bus.mem_lo),    64'(e.lo));
    check({tag, ".mem_whilo"}, 64'(bus.mem_whilo), 64'(e.whilo));
    check({tag, ".hilo_o"},    bus.hilo_o,         e.hilo);
    check({tag, ".cnt_o"},     64'(bus.cnt_o),     64'(e.cnt));
  endtask

  task automatic drive(input vec_t v);
    rst          = v.rst;
    bus.stall    = v.stall;
    bus.ex_wd    = v.wd;
    bus.ex_wdata = v.wdata;
    bus.ex_wreg  = v.wreg;
    bus.ex_hi    = v.hi;
    bus.ex_lo    = v.lo;
    bus.ex_whilo = v.whilo;
    bus.hilo_i   = v.hilo_i;
    bus.cnt_i    = v.cnt_i;
  endtask

  localparam logic [5:0] S_RUN  = 6'b000000;
  localparam logic [5:0] S_BUB  = 6'b001111;
  localparam logic [5:0] S_HOLD = 6'b011111;
  localparam out_t ZERO_OUT = '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0};

  vec_t vt[22];
  vec_t rv;
  out_t model;

  initial begin
    // Each row: rst, stall, wd, wdata, wreg, hi, lo, whilo, hilo_i, cnt_i, {expected after the edge}
    vt[0]  = '{1'b1, S_RUN,  5'd7,  32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, ZERO_OUT};
    vt[1]  = '{1'b1, S_RUN,  5'd7,  32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, ZERO_OUT};
    vt[2]  = '{1'b0, S_HOLD, 5'd7,  32'hDEADBEEF, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, ZERO_OUT};
    vt[3]  = '{1'b0, S_RUN,  5'd7,  32'h12345678, 1'b1, 32'h0, 32'h0, 1'b0, 64'hFFFF, 2'd3,
               '{5'd7, 32'h12345678, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    vt[4]  = '{1'b0, S_BUB,  5'd8,  32'h11111111, 1'b1, 32'h0, 32'h0, 1'b1, 64'h11, 2'd1,
               '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h11, 2'd1}};
    vt[5]  = '{1'b0, S_BUB,  5'd8,  32'h11111111, 1'b1, 32'h0, 32'h0, 1'b1, 64'h22, 2'd2,
               '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h22, 2'd2}};
    vt[6]  = '{1'b0, S_BUB,  5'd8,  32'h11111111, 1'b1, 32'h0, 32'h0, 1'b1, 64'h8000_0000_0000_0033, 2'd3,
               '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h8000_0000_0000_0033, 2'd3}};
    vt[7]  = '{1'b0, S_RUN,  5'd3,  32'hA5A5A5A5, 1'b1, 32'h11, 32'h22, 1'b0, 64'h44, 2'd1,
               '{5'd3, 32'hA5A5A5A5, 1'b1, 32'h11, 32'h22, 1'b0, 64'h0, 2'd0}};
    for (int i = 8; i < 12; i++)
      vt[i] = '{1'b0, S_HOLD, 5'(i), 32'(i), 1'b0, 32'h99, 32'h98, 1'b1, 64'hABC, 2'd2,
                '{5'd3, 32'hA5A5A5A5, 1'b1, 32'h11, 32'h22, 1'b0, 64'h0, 2'd0}};
    vt[12] = '{1'b0, S_BUB,  5'd0,  32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_0000_0002, 2'd1,
               '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_0000_0002, 2'd1}};
    vt[13] = '{1'b0, S_RUN,  5'd0,  32'h0, 1'b0, 32'h5, 32'h6, 1'b1, 64'h777, 2'd2,
               '{5'd0, 32'h0, 1'b0, 32'h5, 32'h6, 1'b1, 64'h0, 2'd0}};
    vt[14] = '{1'b0, S_RUN,  5'd12, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
               '{5'd12, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    vt[15] = '{1'b0, S_HOLD, 5'd13, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
               '{5'd12, 32'hCAFEF00D, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    vt[16] = '{1'b1, S_HOLD, 5'd13, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0, ZERO_OUT};
    vt[17] = '{1'b0, S_RUN,  5'd4,  32'h0BADC0DE, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0,
               '{5'd4, 32'h0BADC0DE, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};
    vt[18] = '{1'b0, S_RUN,  5'd31, 32'hFFFFFFFF, 1'b0, 32'h1, 32'h2, 1'b0, 64'h0, 2'd0,
               '{5'd31, 32'hFFFFFFFF, 1'b0, 32'h1, 32'h2, 1'b0, 64'h0, 2'd0}};
    vt[19] = '{1'b0, S_BUB,  5'd9,  32'h9, 1'b1, 32'h0, 32'h0, 1'b0, 64'h55, 2'd3,
               '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h55, 2'd3}};
    vt[20] = '{1'b0, S_HOLD, 5'd9,  32'h9, 1'b1, 32'h0, 32'h0, 1'b0, 64'h99, 2'd1,
               '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h55, 2'd3}};
    vt[21] = '{1'b0, S_RUN,  5'd1,  32'h1, 1'b1, 32'h0, 32'h0, 1'b0, 64'h99, 2'd1,
               '{5'd1, 32'h1, 1'b1, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0}};

    drive(vt[0]);
    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      drive(vt[i]);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vt[i].exp);
    end

    // Random phase: the model applies the priority rules directly to its own state.
    model = ZERO_OUT;
    for (int i = 0; i < 400; i++) begin
      rv.rst = (i == 0) || ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       rv.stall = S_RUN;
        1:       rv.stall = 6'b000111;
        2:       rv.stall = S_BUB;
        default: rv.stall = S_HOLD;
      endcase
      rv.wd     = 5'($urandom);
      rv.wdata  = $urandom;
      rv.wreg   = 1'($urandom);
      rv.hi     = $urandom;
      rv.lo     = $urandom;
      rv.whilo  = 1'($urandom);
      rv.hilo_i = {$urandom, $urandom};
      rv.cnt_i  = 2'($urandom);
      drive(rv);
      @(posedge clk);
      if (rv.rst) begin
        model = ZERO_OUT;
      end else if (rv.stall[3] == 1'b0) begin
        model = '{rv.wd, rv.wdata, rv.wreg, rv.hi, rv.lo, rv.whilo, 64'h0, 2'd0};
      end else if (rv.stall[4] == 1'b0) begin
        model = '{5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, rv.hilo_i, rv.cnt_i};
      end
      #1;
      check_out($sformatf("rnd%0d", i), model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory stage of the 5-stage core. Every cycle it captures the EX-stage writeback bundle: GPR data/address/enable plus HI/LO data/enable. It then presents that bundle to the memory stage. It obeys the core-wide `stall[5:0]` vector, inserting a bubble or holding as required. It also carries the partial-product/count state that multi-cycle multiply-accumulate instructions (madd/maddu/msub/msubu) need across stall cycles.

## Interface

Parameters: none (widths from shared defines: RegBus = 32, RegAddrBus = 5, DoubleRegBus = 64).

Ports:

- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  6  stall vector. Bit 3 = EX stalled, bit 4 = MEM stalled.
- ex_wdata  in  32  GPR write data from EX.
- ex_wd  in  5  GPR destination address from EX.
- ex_wreg  in  1  GPR write enable from EX.
- ex_hi, ex_lo  in  32 each  HI/LO write data from EX.
- ex_whilo  in  1  HI/LO write enable from EX.
- hilo_i  in  64  EX partial accumulate result (first cycle of madd/msub).
- cnt_i  in  2  EX multi-cycle step counter.
- mem_wdata  out  32  registered to MEM.
- mem_wd  out  5  registered to MEM.
- mem_wreg  out  1  registered to MEM.
- mem_hi, mem_lo  out  32 each  registered to MEM.
- mem_whilo  out  1  registered to MEM.
- hilo_o  out  64  saved partial result, fed back to EX.
- cnt_o  out  2  saved step count, fed back to EX.

## Operation

The bundle register holds mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo and mem_whilo. The carry register holds hilo_o and cnt_o.

Priority on each rising edge:

- **rst = 1:**
  - All outputs 0.
  - mem_wd = NOPRegAddr (5'b0).
  - mem_wreg and mem_whilo = WriteDisable.
  - Overrides stall.
- **Bubble: stall[3] = 1 and stall[4] = 0.**
  - Bundle cleared to reset values, so MEM sees a NOP.
  - Carry register loads hilo_i and cnt_i. This preserves the madd/msub first-cycle product while EX is held.
- **Hold: stall[3] = 1 and stall[4] = 1.**
  - Bundle and carry register keep their values.
- **Advance: stall[3] = 0.**
  - Bundle loads ex_*.
  - Carry register clears to 0, so a completed multi-cycle op leaves no stale state.
  - stall[4] = 1 with stall[3] = 0 is illegal: the controller never stalls a later stage without stalling all earlier ones. The block still advances in this case; the bench flags it with an assertion.

Further rules:

- No combinational path from any input to any output; all outputs are flop outputs.
- cnt_o is stored verbatim. There is no increment or saturation here; EX owns counting.
- Zero-valued enables are not normalised. A bundle with wreg = 0 and non-zero data passes through unchanged.

## Timing

- Latency is 1 cycle: ex_* sampled at edge N appear on mem_* after edge N until edge N+1.
- The bubble takes effect on the edge where the bubble condition is sampled. A stall of k cycles in EX produces k consecutive NOP bundles in MEM.
- The hold condition freezes outputs for every cycle it is asserted. They resume with the next advance or bubble.
- Reset mid-stall:
  - All state clears on that edge.
  - After rst deasserts, the first advance loads ex_* normally.
- Carry across a madd sequence:
  - Cycle 1: EX asserts stall and drives hilo_i = P, cnt_i = 1.
  - Edge: hilo_o = P and cnt_o = 1 are visible to EX in cycle 2.
  - Cycle 2: EX finishes and deasserts stall.
  - Edge: the bundle carries the final HI/LO, and the carry register returns to 0.

## Structure

- Shared defines (existing header): ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RegBus, RegAddrBus, DoubleRegBus. No new constants.
- Single flat module; two always blocks (bundle register, carry register) sharing one decoded mode (RESET/BUBBLE/HOLD/ADVANCE).
- No sub-module warranted.

## Test plan

- **Reset:** assert rst for 2 cycles with ex_wdata = 32'hDEADBEEF, wreg = 1 -> every output 0 and mem_wd = 0 throughout and one edge after release.
- **Advance:** ex_wd = 5'd7, ex_wdata = 32'h12345678, ex_wreg = 1, stall = 0 -> next cycle mem_wd = 7, mem_wdata = 32'h12345678, mem_wreg = 1, hilo_o = 0.
- **Bubble:** stall = 6'b001111 for 3 cycles, ex_wreg = 1 -> mem_wreg = 0 and mem_wdata = 0 for 3 cycles. hilo_o and cnt_o track hilo_i and cnt_i each cycle.
- **Hold:** load wd = 3, wdata = 32'hA5A5A5A5, then stall = 6'b011111 for 4 cycles while ex_* changes -> outputs remain wd = 3, wdata = 32'hA5A5A5A5.
- **madd carry:** cycle 1 stall = 6'b001111, hilo_i = 64'h0000_0001_0000_0002, cnt_i = 1; cycle 2 stall = 0, ex_hi = 5, ex_lo = 6, ex_whilo = 1.
  - After edge 1: hilo_o = 64'h0000_0001_0000_0002, cnt_o = 1, mem_whilo = 0.
  - After edge 2: mem_hi = 5, mem_lo = 6, mem_whilo = 1, hilo_o = 0, cnt_o = 0.
- **Reset during hold:** hold with wreg = 1, then assert rst one cycle -> all outputs 0. After release with stall = 0, the next bundle passes normally.
